core_seq: RTL
=============

// Module: core_seq
// PURPOSE
//  Sequencer for a chain of NCORE dot-product cores (32-word weight RAM + FP32 MAC each).
//  - Loads weights, then streams an input vector through all cores in lock-step.
//  - Shifts the NCORE FP32 results out of the acc_in/acc chain onto a valid/ready stream.
//  - Sits between the host command/DMA streams and the core array.
// PARAMETERS
//  NCORE  16  cores in the chain (2..64)
//  DEPTH  32  words per core weight RAM; AW = $clog2(DEPTH)
// PORTS
//  clk        in   1      clock
//  rst_n      in   1      asynchronous active-low reset
//  cmd_valid  in   1      command handshake
//  cmd_ready  out  1      high only in IDLE
//  cmd_op     in   1      0 = LOAD weights, 1 = RUN
//  cmd_len    in   AW+1   vector length L, 1..DEPTH; 0 is treated as 1
//  w_valid    in   1      weight beat valid
//  w_ready    out  1      weight beat accepted
//  w_data     in   64     two weights per beat: [31:0] first, [63:32] second
//  d_valid    in   1      input word valid
//  d_ready    out  1      input word accepted
//  r_valid    out  1      result valid
//  r_ready    in   1      result accepted
//  r_data     out  32     result = acc_last
//  acc_last   in   32     acc of core NCORE-1
//  init       out  1      to all cores
//  exec       out  1      to all cores
//  outr       out  1      to all cores
//  update     out  1      to all cores
//  write      out  NCORE  one-hot per-core write enable
//  wa         out  AW     write address
//  ra         out  AW     read address
//  ws         out  1      selects wd half
//  wd         out  64     registered copy of w_data
//  busy       out  1      state != IDLE
//  done       out  1      one-cycle pulse when a command finishes
// BEHAVIOUR
//  Reset: state = IDLE; all outputs 0 except cmd_ready = 1. Reset mid-command abandons it; no partial done.
//  FSM states and transitions:
//  - IDLE -> LOAD | INIT on cmd handshake; L latched.
//  - LOAD: weights for core 0 words 0..L-1, then core 1, ... core NCORE-1.
//    - Per beat: w_ready = 1 for one cycle; register wd.
//    - Next cycle: write[c] = 1, ws = 0, wa = k. Following cycle: ws = 1, wa = k+1.
//    - Odd L: upper half of the core's last beat is discarded; the next core starts on a fresh beat.
//    - After the last word of core NCORE-1: done, -> IDLE. w_valid low stalls; write stays 0.
//  - INIT: init = 1 for exactly 1 cycle -> EXEC.
//  - EXEC: d_ready = 1.
//    - exec = d_valid & d_ready, with ra = index 0..L-1; ra advances only on accept.
//    - After the L-th accept -> DRAIN.
//  - DRAIN: 3 idle cycles, covering the core's 2-stage exec pipeline plus the accumulator write.
//    Then update = 1 -> OUT.
//  - OUT: r_valid = 1.
//    - update held 1 until the first r handshake, then 0.
//    - outr = r_valid & r_ready, same cycle as the handshake.
//    - Results emerge in order core NCORE-1 .. core 0.
//    - After the NCORE-th handshake: done, -> IDLE.
//  write, exec, outr and init are mutually exclusive in every cycle.
//  cmd_valid outside IDLE is ignored (cmd_ready = 0).
//  Counters saturate at their terminal value; no wrap-around is ever observable.
// CONFIGURATION
//  CORE_SEQ_PERF_EN defined:
//  - adds out port perf_cycles[31:0]: cycles spent in EXEC+DRAIN+OUT for the last RUN.
//  - cleared on RUN accept; frozen at done.
//  - adds out port perf_stall[31:0]: EXEC cycles with d_valid = 0.
//  Not defined: neither port exists; no counter logic.
// STRUCTURE
//  Package core_seq_pkg:
//  - state_t enum {IDLE, LOAD, INIT, EXEC, DRAIN, OUT}
//  - OP_LOAD/OP_RUN constants, DRAIN_CYC = 3
//  Sub-module core_seq_wpack: 64->32 beat unpacker (wd register, ws toggle, odd-L discard).
//  FSM and counters stay in core_seq.
// TESTING
//  T1 reset: rst_n low mid-EXEC -> outputs 0, cmd_ready = 1 within same cycle; next RUN works.
//  T2 LOAD NCORE=4, L=3, beats 0x2_1, 0x4_3 per core -> write[c] pulses at wa 0,1,2.
//     Upper half of 2nd beat dropped; 8 beats total; one done.
//  T3 RUN L=2, all weights 1.0 (0x3F800000), d = 2.0 then 3.0 -> r_data = 0x40A00000 x NCORE.
//     init 1 cycle before first exec.
//  T4 RUN with d_valid toggling 1/0 -> exec only on accepts, ra 0..L-1, perf_stall = gaps (PERF_EN).
//  T5 r_ready held low 10 cycles in OUT -> r_data stable, update stays 1, no outr.
//     Then 4 results in core order 3,2,1,0.
//  T6 cmd_valid asserted during LOAD and OUT -> ignored; L = 32 and L = 0 (runs as 1) boundaries.

Source files
------------

// File: rtl/core_seq_pkg.sv
// Shared types and constants for the dot-product core sequencer.
package core_seq_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        INIT,
        EXEC,
        DRAIN,
        OUT
    } state_t;

    localparam logic OP_LOAD   = 1'b0;
    localparam logic OP_RUN    = 1'b1;
    localparam int   DRAIN_CYC = 3;

endpackage

// File: rtl/core_seq_wpack.sv
// Splits 64-bit weight beats into two 32-bit RAM writes, low half first.
// Latency: write of the low half one cycle after the beat is taken, high half the cycle after.
// Backpressure: w_ready only while waiting for a beat; odd-length tail drops the high half.
module core_seq_wpack (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        active,
    input  logic        last_word,
    input  logic        w_valid,
    input  logic [63:0] w_data,
    output logic        w_ready,
    output logic        wr,
    output logic        ws,
    output logic [63:0] wd
);

    typedef enum logic [1:0] {PH_GET, PH_LO, PH_HI} phase_t;

    phase_t ph, ph_n;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ph <= PH_GET;
            wd <= '0;
        end else begin
            ph <= ph_n;
            if (w_ready && w_valid) wd <= w_data;
        end
    end

    always_comb begin
        ph_n    = ph;
        w_ready = 1'b0;
        wr      = 1'b0;
        ws      = 1'b0;
        if (!active) begin
            ph_n = PH_GET;
        end else begin
            case (ph)
                PH_GET: begin
                    w_ready = 1'b1;
                    if (w_valid) ph_n = PH_LO;
                end
                PH_LO: begin
                    wr   = 1'b1;
                    // The low half being a core's last word means the high half is padding.
                    ph_n = last_word ? PH_GET : PH_HI;
                end
                PH_HI: begin
                    wr   = 1'b1;
                    ws   = 1'b1;
                    ph_n = PH_GET;
                end
                default: ph_n = PH_GET;
            endcase
        end
    end

endmodule

// File: rtl/core_seq.sv
// Sequencer for a chain of dot-product cores: weight load, lock-step run, result drain.
// Latency: init 1 cycle, then one exec per accepted word, 3 drain cycles, then results stream out.
// Backpressure: w/d/r streams stall the FSM in place; CORE_SEQ_PERF_EN adds perf counters.
module core_seq
    import core_seq_pkg::*;
#(
    parameter int NCORE = 16,
    parameter int DEPTH = 32,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_op,
    input  logic [AW:0]      cmd_len,
    input  logic             w_valid,
    output logic             w_ready,
    input  logic [63:0]      w_data,
    input  logic             d_valid,
    output logic             d_ready,
    output logic             r_valid,
    input  logic             r_ready,
    output logic [31:0]      r_data,
    input  logic [31:0]      acc_last,
    output logic             init,
    output logic             exec,
    output logic             outr,
    output logic             update,
    output logic [NCORE-1:0] write,
    output logic [AW-1:0]    wa,
    output logic [AW-1:0]    ra,
    output logic             ws,
    output logic [63:0]      wd,
    output logic             busy,
`ifdef CORE_SEQ_PERF_EN
    output logic [31:0]      perf_cycles,
    output logic [31:0]      perf_stall,
`endif
    output logic             done
);

    localparam int          CW         = $clog2(NCORE);
    localparam logic [1:0]  DRAIN_LAST = 2'(DRAIN_CYC - 1);

    state_t          state, state_n;
    logic [AW-1:0]   len_m1;
    logic [AW-1:0]   k;
    logic [CW-1:0]   c;
    logic [1:0]      dc;
    logic            hs_seen;
    logic [AW:0]     len_eff;
    logic            wr;
    logic            last_word;
    logic            last_core;

    assign last_word = (k == len_m1);
    assign last_core = (c == CW'(NCORE - 1));

    always_comb begin
        len_eff = cmd_len;
        if (cmd_len == '0)
            len_eff = (AW+1)'(1);
        else if (cmd_len > (AW+1)'(DEPTH))
            len_eff = (AW+1)'(DEPTH);
    end

    core_seq_wpack u_wpack (
        .clk       (clk),
        .rst_n     (rst_n),
        .active    (state == LOAD),
        .last_word (last_word),
        .w_valid   (w_valid),
        .w_data    (w_data),
        .w_ready   (w_ready),
        .wr        (wr),
        .ws        (ws),
        .wd        (wd)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            len_m1  <= '0;
            k       <= '0;
            c       <= '0;
            dc      <= '0;
            hs_seen <= 1'b0;
        end else begin
            state <= state_n;
            case (state)
                IDLE: if (cmd_valid) begin
                    len_m1  <= AW'(len_eff - (AW+1)'(1));
                    k       <= '0;
                    c       <= '0;
                    dc      <= '0;
                    hs_seen <= 1'b0;
                end
                LOAD: if (wr) begin
                    if (last_word) begin
                        k <= '0;
                        if (!last_core) c <= c + 1'b1;
                    end else begin
                        k <= k + 1'b1;
                    end
                end
                EXEC:  if (d_valid) k <= last_word ? '0 : k + 1'b1;
                DRAIN: if (dc != DRAIN_LAST) dc <= dc + 1'b1;
                OUT: if (r_ready) begin
                    hs_seen <= 1'b1;
                    if (!last_core) c <= c + 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_n = state;
        done    = 1'b0;
        init    = 1'b0;
        exec    = 1'b0;
        outr    = 1'b0;
        update  = 1'b0;
        d_ready = 1'b0;
        r_valid = 1'b0;
        case (state)
            IDLE:  if (cmd_valid) state_n = (cmd_op == OP_RUN) ? INIT : LOAD;
            LOAD:  if (wr && last_word && last_core) begin
                done    = 1'b1;
                state_n = IDLE;
            end
            INIT: begin
                init    = 1'b1;
                state_n = EXEC;
            end
            EXEC: begin
                d_ready = 1'b1;
                exec    = d_valid;
                if (d_valid && last_word) state_n = DRAIN;
            end
            DRAIN: if (dc == DRAIN_LAST) state_n = OUT;
            OUT: begin
                r_valid = 1'b1;
                // Parallel load of the chain stays asserted until the first result leaves.
                update  = !hs_seen;
                outr    = r_ready;
                if (r_ready && last_core) begin
                    done    = 1'b1;
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign cmd_ready = (state == IDLE);
    assign busy      = (state != IDLE);
    assign write     = wr ? (NCORE'(1) << c) : '0;
    assign wa        = (state == LOAD) ? k : '0;
    assign ra        = (state == EXEC) ? k : '0;
    assign r_data    = r_valid ? acc_last : '0;

`ifdef CORE_SEQ_PERF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_cycles <= '0;
            perf_stall  <= '0;
        end else if (state == IDLE && cmd_valid && cmd_op == OP_RUN) begin
            perf_cycles <= '0;
            perf_stall  <= '0;
        end else begin
            if ((state == EXEC || state == DRAIN || state == OUT) && perf_cycles != '1)
                perf_cycles <= perf_cycles + 1'b1;
            if (state == EXEC && !d_valid && perf_stall != '1)
                perf_stall <= perf_stall + 1'b1;
        end
    end
`endif

endmodule
